pipe_ctrl: RTL and testbench

Central pipeline sequencer for the 5-stage ARM core. It drives the load and flush strobes of the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB stage registers and the status-register load. It resolves load-use hazards, taken branches and multi-cycle data-memory waits through a small state machine. It also owns a memory-timeout watchdog that halts the core.

---
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage load/flush strobes, memory-wait freeze and timeout halt.
// Define PIPE_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hazard,
   input  logic                 branch_taken,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   input  logic                 status_update,
   output logic                 pc_ld,
   output logic                 if_id_ld,
   output logic                 if_id_flush,
   output logic                 id_exe_ld,
   output logic                 id_exe_flush,
   output logic                 exe_mem_ld,
   output logic                 mem_wb_ld,
   output logic                 status_ld,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic [CNT_WIDTH-1:0] flush_cnt
);

   localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1) + 1;

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t            state, state_next;
   logic [WAIT_W-1:0] wait_cnt, wait_next, wait_inc;
   logic              advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   always_comb begin
      state_next = state;
      wait_next  = wait_cnt;
      wait_inc   = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
      case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_next = MEM_WAIT;
               wait_next  = WAIT_W'(1);
            end else begin
               wait_next  = '0;
            end
         end
         MEM_WAIT: begin
            // mem_ready takes precedence over the timeout in the same cycle
            if (mem_ready) begin
               state_next = RUN;
               wait_next  = '0;
            end else begin
               wait_next = wait_inc;
               if (MEM_TIMEOUT != 0 && 32'(wait_inc) >= MEM_TIMEOUT)
                  state_next = HALT;
            end
         end
         HALT: ;
         default: begin
            state_next = RUN;
            wait_next  = '0;
         end
      endcase
   end

   assign advance = !rst && ((state == RUN && (!mem_req || mem_ready)) ||
                             (state == MEM_WAIT && mem_ready));

   always_comb begin
      pc_ld        = 1'b0;
      if_id_ld     = 1'b0;
      if_id_flush  = 1'b0;
      id_exe_ld    = 1'b0;
      id_exe_flush = 1'b0;
      exe_mem_ld   = 1'b0;
      mem_wb_ld    = 1'b0;
      status_ld    = 1'b0;
      halted       = !rst && state == HALT;
      if (advance) begin
         pc_ld      = 1'b1;
         if_id_ld   = 1'b1;
         id_exe_ld  = 1'b1;
         exe_mem_ld = 1'b1;
         mem_wb_ld  = 1'b1;
         status_ld  = status_update;
         if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
         end else if (hazard) begin
            pc_ld        = 1'b0;
            if_id_ld     = 1'b0;
            id_exe_flush = 1'b1;
         end
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic freeze;

   assign freeze = !rst && ((state == RUN && mem_req && !mem_ready) ||
                            (state == MEM_WAIT && !mem_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (freeze && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (advance && branch_taken && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a transaction-level model of
// outstanding accesses, consecutive-freeze timeout and event counters.
module tb_pipe_ctrl;

   localparam int unsigned TMO = 4;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          rst, hazard, branch_taken, mem_req, mem_ready, status_update;
   logic          pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush;
   logic          exe_mem_ld, mem_wb_ld, status_ld, halted;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // model state
   bit          m_wait, m_halt;
   int unsigned m_freezes, m_stall, m_flush;

   pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .status_update(status_update),
      .pc_ld(pc_ld), .if_id_ld(if_id_ld), .if_id_flush(if_id_flush),
      .id_exe_ld(id_exe_ld), .id_exe_flush(id_exe_flush),
      .exe_mem_ld(exe_mem_ld), .mem_wb_ld(mem_wb_ld), .status_ld(status_ld),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: apply inputs after the falling edge, check, then advance the model.
   task automatic step(input bit r, input bit hz, input bit br, input bit rq,
                       input bit rd, input bit su);
      bit          frz;
      logic [8:0]  exp_v, got_v;
      int unsigned lim;
      @(negedge clk);
      rst = r; hazard = hz; branch_taken = br; mem_req = rq; mem_ready = rd;
      status_update = su;
      #1;
      frz   = m_wait ? !rd : (rq && !rd);
      exp_v = '0;
      if (!r && m_halt)
         exp_v[0] = 1'b1;
      else if (!r && !frz) begin
         // {pc, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush, exe_mem, mem_wb, status, halted}
         exp_v = {(br || !hz), (br || !hz), br, 1'b1, (br || hz), 1'b1, 1'b1, su, 1'b0};
      end
      got_v = {pc_ld, if_id_ld, if_id_flush, id_exe_ld, id_exe_flush,
               exe_mem_ld, mem_wb_ld, status_ld, halted};
      check("strobes", 32'(got_v), 32'(exp_v));
`ifdef PIPE_PERF_CNT_EN
      check("stall_cnt", 32'(stall_cnt), m_stall);
      check("flush_cnt", 32'(flush_cnt), m_flush);
`else
      check("stall_cnt", 32'(stall_cnt), 0);
      check("flush_cnt", 32'(flush_cnt), 0);
`endif
      lim = (TMO < 2) ? 2 : TMO;
      if (r) begin
         m_wait = 0; m_halt = 0; m_freezes = 0; m_stall = 0; m_flush = 0;
      end else if (!m_halt) begin
         if (frz) begin
            if (m_stall < (1 << CW) - 1) m_stall++;
            m_freezes++;
            m_wait = 1;
            if (TMO != 0 && m_freezes >= lim) m_halt = 1;
         end else begin
            if (br && m_flush < (1 << CW) - 1) m_flush++;
            m_wait    = 0;
            m_freezes = 0;
         end
      end
   endtask

   initial begin
      rst = 1; hazard = 0; branch_taken = 0; mem_req = 0; mem_ready = 0; status_update = 0;
      repeat (2) @(posedge clk);
      // reset state, then free run with and without status_update
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      // load-use bubble then recovery
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // branch overrides hazard
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // three-cycle memory wait, release with pending branch, then idle
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 1, 0, 0);
      step(0, 1, 0, 1, 0, 0);
      step(0, 0, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0, 0);
      // timeout: halt from fifth cycle, sticky across mem_ready, cleared by rst
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // ready arriving on the timeout cycle wins
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      // rst during MEM_WAIT
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 3) == 0),
              $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 1) == 1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
